// File: rtl/mult_unit.sv
// Iterative 32-bit shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One iteration per cycle; result, done and write-back select are registered.
module mult_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [1:0]      multOp,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            busy,
  output logic            done,
  output logic            aluResultSrc,
  output logic [XLEN-1:0] multResult
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  state_t              state;
  op_t                 op_q;
  logic [CNT_W-1:0]    count;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     mcand;
  logic                neg_q;

  op_t                 op_in;
  logic                sign_a;
  logic                sign_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [XLEN-1:0]     addend;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   acc_shift;
  logic [2*XLEN-1:0]   product;
  logic                last_iter;

  // Operands enter as magnitudes; the sign is reapplied once to the full product.
  always_comb begin
    op_in  = op_t'(multOp);
    sign_a = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) && operandA[XLEN-1];
    sign_b = (op_in == OP_MULH) && operandB[XLEN-1];
    mag_a  = sign_a ? ('0 - operandA) : operandA;
    mag_b  = sign_b ? ('0 - operandB) : operandB;
  end

  // Low half of acc holds the remaining multiplier bits, high half the partial sum.
  always_comb begin
    addend    = acc[0] ? mcand : '0;
    sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    acc_shift = {sum, acc[XLEN-1:1]};
    product   = neg_q ? ('0 - acc_shift) : acc_shift;
    last_iter = (count == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      op_q         <= OP_MUL;
      count        <= '0;
      acc          <= '0;
      mcand        <= '0;
      neg_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aluResultSrc <= 1'b0;
      multResult   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag_a;
            acc   <= {{XLEN{1'b0}}, mag_b};
            op_q  <= op_in;
            neg_q <= sign_a ^ sign_b;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_shift;
          count <= count + 1'b1;
          if (last_iter) begin
            multResult   <= (op_q == OP_MUL) ? product[XLEN-1:0]
                                             : product[2*XLEN-1:XLEN];
            busy         <= 1'b0;
            done         <= 1'b1;
            aluResultSrc <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          done         <= 1'b0;
          aluResultSrc <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy         <= 1'b0;
          done         <= 1'b0;
          aluResultSrc <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
